// File: rtl/pipe_stage_fifo_pkg.sv
// Shared constants and helpers for elastic pipeline stage buffers.
// Also holds the payload widths that stage wrappers use to pack their fields.
package pipe_stage_fifo_pkg;

  localparam int PIPE_DEPTH_DEFAULT = 2;

  // MEM/WB field widths; a MEM/WB wrapper concatenates these onto in_data
  localparam int MEMWB_RESULT_W   = 32;
  localparam int MEMWB_RDATA_W    = 32;
  localparam int MEMWB_RD_W       = 5;
  localparam int MEMWB_REGWRITE_W = 1;
  localparam int MEMWB_MEMTOREG_W = 1;
  localparam int MEMWB_PAYLOAD_WIDTH = MEMWB_RESULT_W + MEMWB_RDATA_W + MEMWB_RD_W
                                     + MEMWB_REGWRITE_W + MEMWB_MEMTOREG_W;

  typedef struct packed {
    logic [MEMWB_RESULT_W-1:0]   result;
    logic [MEMWB_RDATA_W-1:0]    rdata;
    logic [MEMWB_RD_W-1:0]       rd;
    logic [MEMWB_REGWRITE_W-1:0] regwrite;
    logic [MEMWB_MEMTOREG_W-1:0] memtoreg;
  } memwb_payload_t;

  typedef enum logic [1:0] {
    EV_IDLE = 2'b00,
    EV_POP  = 2'b01,
    EV_PUSH = 2'b10,
    EV_BOTH = 2'b11
  } fifo_event_e;

  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    if (ptr >= depth - 32'd1) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/pipe_stage_fifo.sv
// Elastic inter-stage pipeline register: DEPTH-entry FIFO with valid/ready on both
// sides, synchronous flush, and no combinational path between the two handshakes.
module pipe_stage_fifo
  import pipe_stage_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = PIPE_DEPTH_DEFAULT,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             push_s;
  logic             pop_s;
  logic             mem_we_s;
  fifo_event_e      event_s;
  logic [PTR_W-1:0] wr_ptr_inc_s;
  logic [PTR_W-1:0] rd_ptr_inc_s;

  // Handshakes qualify only against registered flags, so out_ready never reaches in_ready.
  always_comb begin
    push_s       = in_valid & in_ready_q;
    pop_s        = out_valid_q & out_ready;
    mem_we_s     = push_s & ~flush;
    event_s      = fifo_event_e'({push_s, pop_s});
    wr_ptr_inc_s = PTR_W'(wrap_inc(32'(wr_ptr_q), 32'(DEPTH)));
    rd_ptr_inc_s = PTR_W'(wrap_inc(32'(rd_ptr_q), 32'(DEPTH)));
  end

  // Next-state control; flush overrides any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      case (event_s)
        EV_PUSH: begin
          wr_ptr_d = wr_ptr_inc_s;
          count_d  = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        EV_POP: begin
          rd_ptr_d = rd_ptr_inc_s;
          count_d  = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
        EV_BOTH: begin
          wr_ptr_d = wr_ptr_inc_s;
          rd_ptr_d = rd_ptr_inc_s;
        end
        EV_IDLE: begin
          count_d  = count_q;
        end
        default: begin
          count_d  = count_q;
        end
      endcase
    end
  end

  // Status flags are precomputed from the next occupancy so they leave as flops.
  always_comb begin
    in_ready_d  = (count_d != CNT_W'(DEPTH));
    out_valid_d = (count_d != {CNT_W{1'b0}});
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Payload storage is deliberately not reset; out_data masking hides stale entries.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Head payload, forced to zero while the buffer is empty.
  always_comb begin
    if (out_valid_q) begin
      out_data = mem_q[rd_ptr_q];
    end else begin
      out_data = {WIDTH{1'b0}};
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed bench for pipe_stage_fifo at DEPTH=2, DEPTH=1 and DEPTH=3.
module tb_pipe_stage_fifo;

  logic clk;
  logic rst;

  logic        flush2, in_valid2, in_ready2, out_valid2, out_ready2;
  logic [31:0] in_data2, out_data2;
  logic [1:0]  count2;

  logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [31:0] in_data1, out_data1;
  logic [0:0]  count1;

  logic        flush3, in_valid3, in_ready3, out_valid3, out_ready3;
  logic [31:0] in_data3, out_data3;
  logic [1:0]  count3;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_q[$];
  int          sent, got;
  logic        do_push, do_pop;

  pipe_stage_fifo #(.WIDTH(32), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .count(count2)
  );

  pipe_stage_fifo #(.WIDTH(32), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .count(count1)
  );

  pipe_stage_fifo #(.WIDTH(32), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush3),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .count(count3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0; in_data2 = 32'h0;
    flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; in_data1 = 32'h0;
    flush3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0; in_data3 = 32'h0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();

    // Reset state
    chk("rst_count",     32'(count2), 32'd0);
    chk("rst_out_valid", 32'(out_valid2), 32'd0);
    chk("rst_in_ready",  32'(in_ready2), 32'd1);
    chk("rst_out_data",  out_data2, 32'd0);

    // Stream: one transfer per cycle, one cycle latency, count stays 1
    out_ready2 = 1'b1;
    in_valid2  = 1'b1;
    in_data2 = 32'h11; cyc();
    chk("s2_data_11", out_data2, 32'h11);
    chk("s2_count_11", 32'(count2), 32'd1);
    in_data2 = 32'h22; cyc();
    chk("s2_data_22", out_data2, 32'h22);
    chk("s2_count_22", 32'(count2), 32'd1);
    in_data2 = 32'h33; cyc();
    chk("s2_data_33", out_data2, 32'h33);
    chk("s2_in_ready", 32'(in_ready2), 32'd1);
    in_data2 = 32'h44; cyc();
    chk("s2_data_44", out_data2, 32'h44);
    chk("s2_count_44", 32'(count2), 32'd1);
    in_valid2 = 1'b0; cyc();
    chk("s2_drain_valid", 32'(out_valid2), 32'd0);
    chk("s2_drain_data", out_data2, 32'd0);

    // Backpressure, then full + pop, then simultaneous push/pop
    out_ready2 = 1'b0;
    in_valid2  = 1'b1;
    in_data2 = 32'hA; cyc();
    chk("s3_count_a", 32'(count2), 32'd1);
    in_data2 = 32'hB; cyc();
    chk("s3_count_full", 32'(count2), 32'd2);
    chk("s3_in_ready_full", 32'(in_ready2), 32'd0);
    chk("s3_head_a", out_data2, 32'hA);
    in_data2 = 32'hC; cyc();
    chk("s3_held_count", 32'(count2), 32'd2);
    chk("s3_held_head", out_data2, 32'hA);
    out_ready2 = 1'b1; cyc();
    chk("s4_pop_only_count", 32'(count2), 32'd1);
    chk("s3_head_b", out_data2, 32'hB);
    cyc();
    chk("s4_both_count", 32'(count2), 32'd1);
    chk("s3_head_c", out_data2, 32'hC);
    in_valid2 = 1'b0; cyc();
    chk("s3_empty", 32'(count2), 32'd0);

    // Flush while full with a pending push
    out_ready2 = 1'b0;
    in_valid2  = 1'b1;
    in_data2 = 32'h1; cyc();
    in_data2 = 32'h2; cyc();
    chk("s5_pre_count", 32'(count2), 32'd2);
    in_data2 = 32'hDEAD; flush2 = 1'b1; out_ready2 = 1'b1; cyc();
    chk("s5_count", 32'(count2), 32'd0);
    chk("s5_out_valid", 32'(out_valid2), 32'd0);
    chk("s5_out_data", out_data2, 32'd0);
    flush2 = 1'b0; in_valid2 = 1'b0; cyc();
    chk("s5_no_dead", out_data2, 32'd0);

    // Flush with count=1 drops an otherwise-acceptable push
    in_valid2 = 1'b1; out_ready2 = 1'b0; in_data2 = 32'h5; cyc();
    in_data2 = 32'hDEAD; flush2 = 1'b1; cyc();
    flush2 = 1'b0; in_valid2 = 1'b0;
    chk("s5b_count", 32'(count2), 32'd0);
    chk("s5b_out_valid", 32'(out_valid2), 32'd0);

    // Async reset with count=2, observed before the next clock edge
    in_valid2 = 1'b1; in_data2 = 32'h7; cyc();
    in_data2 = 32'h8; cyc();
    in_valid2 = 1'b0;
    chk("s1_pre_count", 32'(count2), 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("s1_count", 32'(count2), 32'd0);
    chk("s1_out_valid", 32'(out_valid2), 32'd0);
    chk("s1_out_data", out_data2, 32'd0);
    chk("s1_in_ready", 32'(in_ready2), 32'd1);
    cyc();
    rst = 1'b1;
    out_ready2 = 1'b0;
    cyc();
    chk("s1_after_count", 32'(count2), 32'd0);

    // DEPTH=1: full blocks a same-cycle push, so out_valid alternates
    in_valid1 = 1'b1; out_ready1 = 1'b1; in_data1 = 32'h55;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("s6_out_valid", 32'(out_valid1), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("s6_in_ready",  32'(in_ready1),  (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("s6_count",     32'(count1),     (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("s6_out_data",  out_data1,       (i % 2 == 0) ? 32'h55 : 32'd0);
    end
    in_valid1 = 1'b0;

    // DEPTH=3: random consumer stalls, order preserved across pointer wrap
    sent = 0;
    got  = 0;
    for (int c = 0; c < 300 && got < 10; c++) begin
      in_valid3  = (sent < 10);
      in_data3   = 32'h100 + 32'(sent);
      out_ready3 = 1'($urandom_range(0, 1));
      chk("s7_count", 32'(count3), 32'(model_q.size()));
      chk("s7_out_valid", 32'(out_valid3), (model_q.size() != 0) ? 32'd1 : 32'd0);
      chk("s7_in_ready", 32'(in_ready3), (model_q.size() != 3) ? 32'd1 : 32'd0);
      if (model_q.size() != 0) begin
        chk("s7_data", out_data3, model_q[0]);
      end
      do_push = in_valid3 && (model_q.size() < 3);
      do_pop  = (model_q.size() != 0) && out_ready3;
      cyc();
      if (do_pop) begin
        void'(model_q.pop_front());
        got++;
      end
      if (do_push) begin
        model_q.push_back(in_data3);
        sent++;
      end
    end
    in_valid3 = 1'b0;
    out_ready3 = 1'b0;
    chk("s7_all_received", 32'(got), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
